// File: rtl/program_counter.sv
// Registered program counter with previous-PC capture, PC+STEP lookahead and alignment flag.
// Optional stall input is enabled by defining PC_STALL_EN.
module program_counter #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000,
  parameter int               STEP         = 4,
  parameter int               ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] next_pc,
`ifdef PC_STALL_EN
  input  logic             stall,
`endif
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic [WIDTH-1:0] prev_pc,
  output logic             wrap,
  output logic             misaligned
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_prev_pc;
  logic [WIDTH:0]   w_sum;
  logic             w_load;

`ifdef PC_STALL_EN
  assign w_load = ~stall;
`else
  assign w_load = 1'b1;
`endif

  // PC and prev_pc registers; reset dominates, a stalled edge holds both
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_VECTOR;
      r_prev_pc <= RESET_VECTOR;
    end else if (w_load) begin
      r_pc      <= next_pc;
      r_prev_pc <= r_pc;
    end else begin
      r_pc      <= r_pc;
      r_prev_pc <= r_prev_pc;
    end
  end

  // One extra bit keeps the carry-out so wrap is exact for any STEP
  assign w_sum = {1'b0, r_pc} + (WIDTH+1)'(STEP);

  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign misaligned = |r_pc[ALIGN_BITS-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

  assign PC           = r_pc;
  assign prev_pc      = r_prev_pc;
  assign pc_plus_step = w_sum[WIDTH-1:0];
  assign wrap         = w_sum[WIDTH];

endmodule

// File: tb/tb_program_counter.sv
// Directed-vector bench for program_counter; stall vectors run only when PC_STALL_EN is defined.
module tb_program_counter;

  logic        clk;
  logic        reset;
  logic [15:0] next_pc;
  logic        stall;
  logic [15:0] PC;
  logic [15:0] pc_plus_step;
  logic [15:0] prev_pc;
  logic        wrap;
  logic        misaligned;

  int n_vec;
  int n_err;

  program_counter dut (
    .clk          (clk),
    .reset        (reset),
    .next_pc      (next_pc),
`ifdef PC_STALL_EN
    .stall        (stall),
`endif
    .PC           (PC),
    .pc_plus_step (pc_plus_step),
    .prev_pc      (prev_pc),
    .wrap         (wrap),
    .misaligned   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic [15:0] e_prev,
                         input logic [15:0] e_pps, input logic e_wrap, input logic e_mis);
    chk({tag, ".pc"},   {16'h0000, PC},           {16'h0000, e_pc});
    chk({tag, ".prev"}, {16'h0000, prev_pc},      {16'h0000, e_prev});
    chk({tag, ".pps"},  {16'h0000, pc_plus_step}, {16'h0000, e_pps});
    chk({tag, ".wrap"}, {31'h0, wrap},            {31'h0, e_wrap});
    chk({tag, ".mis"},  {31'h0, misaligned},      {31'h0, e_mis});
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b0;
    stall   = 1'b0;
    next_pc = 16'h1234;
    #3;
    chk_all("rst_async", 16'h0000, 16'h0000, 16'h0004, 1'b0, 1'b0);
    tick();
    tick();
    chk_all("rst_clk", 16'h0000, 16'h0000, 16'h0004, 1'b0, 1'b0);

    reset   = 1'b1;
    next_pc = 16'h0004;
    tick();
    chk_all("ld4", 16'h0004, 16'h0000, 16'h0008, 1'b0, 1'b0);
    next_pc = 16'h0008;
    tick();
    chk_all("ld8", 16'h0008, 16'h0004, 16'h000C, 1'b0, 1'b0);
    next_pc = 16'h000C;
    tick();
    chk_all("ldC", 16'h000C, 16'h0008, 16'h0010, 1'b0, 1'b0);

    // Reset asserted mid-cycle must clear PC without waiting for an edge
    next_pc = 16'h0020;
    #3;
    reset = 1'b0;
    #1;
    chk_all("rst_mid", 16'h0000, 16'h0000, 16'h0004, 1'b0, 1'b0);
    tick();
    chk("rst_mid_edge.pc", {16'h0000, PC}, 32'h0000_0000);
    reset   = 1'b1;
    next_pc = 16'h0010;
    tick();
    chk_all("ld10", 16'h0010, 16'h0000, 16'h0014, 1'b0, 1'b0);
    next_pc = 16'h0014;
    tick();
    chk_all("ld14", 16'h0014, 16'h0010, 16'h0018, 1'b0, 1'b0);

    next_pc = 16'hFFFC;
    tick();
    chk_all("ldFFFC", 16'hFFFC, 16'h0014, 16'h0000, 1'b1, 1'b0);
    next_pc = 16'h0006;
    tick();
    chk_all("ld6", 16'h0006, 16'hFFFC, 16'h000A, 1'b0, 1'b1);
    tick();
    chk_all("hold6", 16'h0006, 16'h0006, 16'h000A, 1'b0, 1'b1);
    next_pc = 16'hFFFF;
    tick();
    chk_all("ldFFFF", 16'hFFFF, 16'h0006, 16'h0003, 1'b1, 1'b1);

`ifdef PC_STALL_EN
    next_pc = 16'h0008;
    tick();
    chk_all("ld8b", 16'h0008, 16'hFFFF, 16'h000C, 1'b0, 1'b0);
    stall   = 1'b1;
    next_pc = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.pc", {16'h0000, PC}, 32'h0000_0008);
      chk("stall.prev", {16'h0000, prev_pc}, 32'h0000_FFFF);
    end
    stall = 1'b0;
    tick();
    chk_all("unstall", 16'h0020, 16'h0008, 16'h0024, 1'b0, 1'b0);
`else
    next_pc = 16'h0008;
    tick();
    chk_all("ld8b", 16'h0008, 16'hFFFF, 16'h000C, 1'b0, 1'b0);
    stall   = 1'b1;
    next_pc = 16'h0020;
    tick();
    chk_all("nostall", 16'h0020, 16'h0008, 16'h0024, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
